// File: rtl/tt_pkg.sv
// tt_pkg: shared states, sizes and drive mapping for the truth-table sweep checker
package tt_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam int N_INPUTS = 4;
  localparam int N_ROWS = 16;
  function automatic logic [N_INPUTS-1:0] idx_to_drv(input logic [3:0] idx);
    return {idx[3], idx[2], idx[1], idx[0]};
  endfunction
endpackage

// File: rtl/tt_sync2.sv
// tt_sync2: two-flop synchroniser with asynchronous active-low reset
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps a 4-input netlist through all rows and checks its truth table
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 8,
  parameter int          SAMPLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'h9F8A,
  parameter int          CW            = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_out,
  output logic        drv_in1,
  output logic        drv_in2,
  output logic        drv_in3,
  output logic        drv_in4,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [15:0] unstable,
  output logic        pass
);
  if (SETTLE_CYCLES < 2 || SAMPLE_CYCLES < 1 || SETTLE_CYCLES > 2**CW || SAMPLE_CYCLES > 2**CW) begin : g_bad_params
    $error("tt_sweep_checker: SETTLE_CYCLES must be >= 2, SAMPLE_CYCLES >= 1, both must fit in CW bits");
  end
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic [N_INPUTS-1:0] drv_q, drv_d;
  logic [N_ROWS-1:0]   sig_q, sig_d;
  logic [N_ROWS-1:0]   unst_q, unst_d;
  logic                ref_q, ref_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;
  logic                smp;
  tt_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(dut_out), .q(smp));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    drv_d   = drv_q;
    sig_d   = sig_q;
    unst_d  = unst_q;
    ref_d   = ref_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d   = '0;
          unst_d  = '0;
          pass_d  = 1'b0;
          idx_d   = 4'd0;
          cnt_d   = '0;
          drv_d   = idx_to_drv(4'd0);
          state_d = APPLY;
        end
      end
      APPLY: begin
        cnt_d   = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == SETTLE_LAST) ? SAMPLE : APPLY;
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          sig_d[idx_q] = smp;
          ref_d        = smp;
        end else if (smp != ref_q) begin
          unst_d[idx_q] = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = '0;
          if (idx_q == 4'hF) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (sig_d == EXPECTED) && (unst_d == '0);
          end else begin
            idx_d   = idx_q + 4'd1;
            drv_d   = idx_to_drv(idx_q + 4'd1);
            state_d = APPLY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      drv_q   <= '0;
      sig_q   <= '0;
      unst_q  <= '0;
      ref_q   <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      drv_q   <= drv_d;
      sig_q   <= sig_d;
      unst_q  <= unst_d;
      ref_q   <= ref_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end
  assign {drv_in1, drv_in2, drv_in3, drv_in4} = drv_q;
  assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
  assign done      = done_q;
  assign signature = sig_q;
  assign unstable  = unst_q;
  assign pass      = pass_q;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: directed table-driven bench for the truth-table sweep checker
module tb_tt_sweep_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dut_out;
  logic        drv_in1, drv_in2, drv_in3, drv_in4;
  logic        busy, done, pass;
  logic [15:0] signature, unstable;
  logic        a_dut_out;
  logic        a_drv_in1, a_drv_in2, a_drv_in3, a_drv_in4;
  logic        a_busy, a_done, a_pass;
  logic [15:0] a_signature, a_unstable;
  logic [3:0]  drv, a_drv;
  logic [15:0] lut = 16'h9F8A;
  logic        tog = 1'b0;
  int          mode = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  typedef struct {
    int          mode;
    logic [15:0] sig;
    logic [15:0] unst;
    logic [15:0] mask;
    logic        pass;
  } vec_t;
  vec_t vecs[4];
  always #5 clk = ~clk;
  always @(negedge clk) tog = ~tog;
  assign drv   = {drv_in1, drv_in2, drv_in3, drv_in4};
  assign a_drv = {a_drv_in1, a_drv_in2, a_drv_in3, a_drv_in4};
  assign a_dut_out = a_drv_in4;
  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0: dut_out = drv_in1;
      1: dut_out = lut[drv];
      2: dut_out = drv_in4;
      3: dut_out = (drv == 4'd5) ? tog : lut[drv];
      default: dut_out = 1'b0;
    endcase
  end
  tt_sweep_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3), .drv_in4(drv_in4),
    .busy(busy), .done(done), .signature(signature), .unstable(unstable), .pass(pass)
  );
  tt_sweep_checker #(.EXPECTED(16'hAAAA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(a_dut_out),
    .drv_in1(a_drv_in1), .drv_in2(a_drv_in2), .drv_in3(a_drv_in3), .drv_in4(a_drv_in4),
    .busy(a_busy), .done(a_done), .signature(a_signature), .unstable(a_unstable), .pass(a_pass)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " main outputs"}, {drv, busy, done, pass, signature, unstable}, 32'd0);
    chk({tag, " alt outputs"}, {a_drv, a_busy, a_done, a_pass, a_signature, a_unstable}, 32'd0);
  endtask
  task automatic run_sweep(input bit hold, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 1000) begin
      busy_n += int'(busy);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  initial begin
    int lat, busy_n;
    vecs[0] = '{0, 16'hFF00, 16'h0000, 16'hFFFF, 1'b0};
    vecs[1] = '{1, 16'h9F8A, 16'h0000, 16'hFFFF, 1'b1};
    vecs[2] = '{2, 16'hAAAA, 16'h0000, 16'hFFFF, 1'b0};
    vecs[3] = '{3, 16'h9F8A, 16'h0020, 16'hFFDF, 1'b0};
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("idle");
    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      run_sweep(1'b0, lat, busy_n);
      chk($sformatf("v%0d latency", i), lat, 192);
      chk($sformatf("v%0d busy cycles", i), busy_n, 192);
      chk($sformatf("v%0d signature", i), signature & vecs[i].mask, vecs[i].sig & vecs[i].mask);
      chk($sformatf("v%0d unstable", i), unstable, vecs[i].unst);
      chk($sformatf("v%0d pass", i), pass, vecs[i].pass);
      chk($sformatf("v%0d drv final", i), drv, 4'hF);
      chk($sformatf("v%0d alt done", i), a_done, 1'b1);
      chk($sformatf("v%0d alt signature", i), a_signature, 16'hAAAA);
      chk($sformatf("v%0d alt unstable/pass", i), {a_unstable, a_pass}, {16'h0000, 1'b1});
      chk($sformatf("v%0d alt drv", i), a_drv, 4'hF);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done width", i), {done, a_done}, 2'b00);
      chk($sformatf("v%0d hold", i), {busy, pass, unstable}, {1'b0, vecs[i].pass, vecs[i].unst});
    end
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (drv != 4'd9 && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("reach index 9", drv, 4'd9);
    chk("busy at index 9", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b0, lat, busy_n);
    chk("post-reset latency", lat, 192);
    chk("post-reset signature", signature, 16'h9F8A);
    chk("post-reset unstable/pass", {unstable, pass}, {16'h0000, 1'b1});
    mode = 0;
    run_sweep(1'b1, lat, busy_n);
    chk("held start latency", lat, 192);
    chk("held start busy", busy_n, 192);
    chk("held start signature", signature, 16'hFF00);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done state holds", {busy, done, signature}, {1'b0, 1'b0, 16'hFF00});
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart clears", {busy, pass, signature, unstable}, {1'b1, 1'b0, 16'h0000, 16'h0000});
    chk("restart alt clears", {a_busy, a_pass, a_signature}, {1'b1, 1'b0, 16'h0000});
    lat = 0;
    while (!done && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("second sweep latency", lat, 192);
    chk("second sweep signature", signature, 16'hFF00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
